// File: rtl/fifo_serial_tx_if.sv
// FIFO-side and serial-side signals of the drain stage.
// The master side is the FIFO plus its controller; the slave side is fifo_serial_tx.
interface fifo_serial_tx_if #(
    parameter int DATO_WIDTH = 3
);
    logic                  enable;
    logic                  empy;
    logic [DATO_WIDTH-1:0] datin;
    logic                  rd;
    logic                  tx;
    logic                  busy;
    logic                  frame_done;

    modport master (
        output enable, empy, datin,
        input  rd, tx, busy, frame_done
    );

    modport slave (
        input  enable, empy, datin,
        output rd, tx, busy, frame_done
    );
endinterface

// File: rtl/fifo_serial_tx.sv
// Pops one FIFO word at a time and sends it LSB-first as a serial frame:
// start bit, data bits, optional even parity, stop bit.
module fifo_serial_tx #(
    parameter int DATO_WIDTH   = 3,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY       = 0
) (
    input  logic            clk,
    input  logic            rst,
    fifo_serial_tx_if.slave bus
);
    localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATO_WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATO_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, READ, WAIT, START, DATA, PAR, STOP} state_t;

    state_t                state;
    logic [DIV_W-1:0]      div;
    logic [BIT_W-1:0]      bitcnt;
    logic [DATO_WIDTH-1:0] shreg;
    logic [DATO_WIDTH-1:0] sh_next;
    logic                  par_bit;
    logic                  bit_end;

    assign sh_next = shreg >> 1;
    assign bit_end = (div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            div            <= '0;
            bitcnt         <= '0;
            shreg          <= '0;
            par_bit        <= 1'b0;
            bus.rd         <= 1'b0;
            bus.tx         <= 1'b1;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.rd         <= 1'b0;
            bus.frame_done <= 1'b0;
            // divider only runs while a bit is on the line
            if (state inside {START, DATA, PAR, STOP})
                div <= bit_end ? '0 : div + 1'b1;
            case (state)
                IDLE: begin
                    if (bus.enable && !bus.empy) begin
                        state  <= READ;
                        bus.rd <= 1'b1;
                    end
                end
                READ: begin
                    state    <= WAIT;
                    bus.busy <= 1'b1;
                end
                WAIT: begin
                    // datout has had a full cycle to settle after the strobe
                    shreg   <= bus.datin;
                    par_bit <= ^bus.datin;
                    div     <= '0;
                    bus.tx  <= 1'b0;
                    state   <= START;
                end
                START: begin
                    if (bit_end) begin
                        state  <= DATA;
                        bus.tx <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shreg <= sh_next;
                        if (bitcnt == BIT_LAST) begin
                            bitcnt <= '0;
                            if (PARITY != 0) begin
                                state  <= PAR;
                                bus.tx <= par_bit;
                            end else begin
                                state  <= STOP;
                                bus.tx <= 1'b1;
                            end
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                            bus.tx <= sh_next[0];
                        end
                    end
                end
                PAR: begin
                    if (bit_end) begin
                        state  <= STOP;
                        bus.tx <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state          <= IDLE;
                        bus.busy       <= 1'b0;
                        bus.frame_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: a no-parity and an even-parity instance, each fed by a FIFO model,
// checked every cycle against a frame-level reference plus table vectors and corner sequences.
module tb_fifo_serial_tx;
    localparam int DW  = 3;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fifo_serial_tx_if #(.DATO_WIDTH(DW)) b0 ();
    fifo_serial_tx_if #(.DATO_WIDTH(DW)) b1 ();

    fifo_serial_tx #(.DATO_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY(0)) u0 (
        .clk(clk), .rst(rst), .bus(b0.slave));
    fifo_serial_tx #(.DATO_WIDTH(DW), .CLKS_PER_BIT(CPB), .PARITY(1)) u1 (
        .clk(clk), .rst(rst), .bus(b1.slave));

    // FIFO model per instance: circular store, head advanced by the DUT's read strobe
    logic [DW-1:0] fmem [2][64];
    int            head [2] = '{0, 0};
    int            tail [2] = '{0, 0};
    logic          en   [2] = '{1'b0, 1'b0};
    logic [DW-1:0] dout [2];

    assign b0.enable = en[0];
    assign b1.enable = en[1];
    assign b0.empy   = (head[0] == tail[0]);
    assign b1.empy   = (head[1] == tail[1]);
    assign b0.datin  = dout[0];
    assign b1.datin  = dout[1];

    logic rd_w [2], tx_w [2], bz_w [2], fd_w [2];
    assign rd_w[0] = b0.rd;         assign rd_w[1] = b1.rd;
    assign tx_w[0] = b0.tx;         assign tx_w[1] = b1.tx;
    assign bz_w[0] = b0.busy;       assign bz_w[1] = b1.busy;
    assign fd_w[0] = b0.frame_done; assign fd_w[1] = b1.frame_done;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Frame as a bit list, index 0 first on the line
    function automatic logic [7:0] frame_bits(input logic [DW-1:0] w, input int par);
        logic [7:0] f;
        int n;
        f = '1;
        f[0] = 1'b0;
        n = 1;
        for (int i = 0; i < DW; i++) begin
            f[n] = w[i];
            n++;
        end
        if (par != 0) f[n] = ($countones(w) % 2 == 1);
        return f;
    endfunction

    // Reference: a word accepted at edge s is strobed in cycle s, its frame occupies
    // cycles s+2 .. s+1+len, done pulses in s+2+len, next accept possible at s+3+len.
    int            st   [2] = '{-1000, -1000};
    int            nxt  [2] = '{0, 0};
    logic [7:0]    fb   [2];
    logic          s_rst = 1'b1;
    logic          s_en  [2] = '{1'b0, 1'b0};
    logic          s_emp [2] = '{1'b1, 1'b1};

    always @(negedge clk) begin
        int k, fl;
        logic etx;
        for (int d = 0; d < 2; d++) begin
            k  = cyc;
            fl = (2 + DW + d) * CPB;
            if (s_rst) begin
                st[d]  = -1000;
                nxt[d] = k + 1;
            end else if (k >= nxt[d] && s_en[d] && !s_emp[d]) begin
                st[d]  = k;
                nxt[d] = k + 3 + fl;
                fb[d]  = frame_bits(fmem[d][head[d] % 64], d);
            end
            etx = 1'b1;
            if (k >= st[d] + 2 && k < st[d] + 2 + fl) etx = fb[d][(k - st[d] - 2) / CPB];
            chk($sformatf("rd%0d", d),   rd_w[d], int'(k == st[d]));
            chk($sformatf("tx%0d", d),   tx_w[d], int'(etx));
            chk($sformatf("busy%0d", d), bz_w[d], int'(k >= st[d] + 1 && k <= st[d] + 1 + fl));
            chk($sformatf("fd%0d", d),   fd_w[d], int'(k == st[d] + 2 + fl));
            if (rd_w[d] && head[d] != tail[d]) begin
                dout[d] = fmem[d][head[d] % 64];
                head[d]++;
            end
            s_en[d]  = en[d];
            s_emp[d] = (head[d] == tail[d]);
        end
        s_rst = rst;
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input int d, input logic [DW-1:0] w);
        fmem[d][tail[d] % 64] = w;
        tail[d]++;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) step();
    endtask

    task automatic wait_rd(input int d, input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound && at < 0; i++) begin
            step();
            if (rd_w[d]) at = cyc;
        end
        if (at < 0) chk("rd_timeout", 0, 1);
    endtask

    typedef struct {
        int            d;
        logic [DW-1:0] w;
        logic [7:0]    exp;
        int            nb;
    } vec_t;

    vec_t vt [8];

    initial begin
        int s, n_rd, n_fd, n_low;
        int r [3];
        dout[0] = '0;
        dout[1] = '0;

        // bit i of exp is the i-th bit on the line
        vt[0] = '{0, 3'b101, 8'h1A, 5};
        vt[1] = '{0, 3'b001, 8'h12, 5};
        vt[2] = '{0, 3'b110, 8'h1C, 5};
        vt[3] = '{0, 3'b111, 8'h1E, 5};
        vt[4] = '{0, 3'b011, 8'h16, 5};
        vt[5] = '{1, 3'b110, 8'h2C, 6};
        vt[6] = '{1, 3'b100, 8'h38, 6};
        vt[7] = '{1, 3'b000, 8'h20, 6};

        // reset held two cycles with a word waiting and enable high
        push(0, 3'b010);
        en[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_tx", tx_w[0], 1);
            chk("rst_rd", rd_w[0], 0);
            chk("rst_busy", bz_w[0], 0);
            chk("rst_fd", fd_w[0], 0);
        end
        rst = 1'b0;
        step();
        chk("rst_first_rd", rd_w[0], 1);
        en[0] = 1'b0;
        step(25);

        // table vectors: one word each, bits sampled mid-bit
        for (int i = 0; i < 8; i++) begin
            int d, fl;
            d  = vt[i].d;
            fl = vt[i].nb * CPB;
            push(d, vt[i].w);
            en[d] = 1'b1;
            wait_rd(d, 10, s);
            en[d] = 1'b0;
            if (s >= 0) begin
                for (int b = 0; b < vt[i].nb; b++) begin
                    wait_cyc(s + 2 + b * CPB + CPB / 2);
                    chk($sformatf("tbl%0d_bit%0d", i, b), tx_w[d], int'(vt[i].exp[b]));
                end
                wait_cyc(s + 2 + fl);
                chk("tbl_fd", fd_w[d], 1);
                wait_cyc(s + 3 + fl);
                chk("tbl_fd_end", fd_w[d], 0);
            end
            step(3);
        end

        // empty FIFO with enable high
        en[0] = 1'b1;
        n_rd = 0;
        n_low = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            n_rd  += int'(rd_w[0]);
            n_low += int'(!tx_w[0]);
        end
        chk("empty_rd", n_rd, 0);
        chk("empty_tx_low", n_low, 0);
        en[0] = 1'b0;
        step(2);

        // back-to-back words
        push(0, 3'b001);
        push(0, 3'b110);
        push(0, 3'b111);
        en[0] = 1'b1;
        n_rd = 0;
        n_fd = 0;
        for (int i = 0; i < 85; i++) begin
            step();
            if (rd_w[0]) begin
                if (n_rd < 3) r[n_rd] = cyc;
                n_rd++;
            end
            n_fd += int'(fd_w[0]);
        end
        en[0] = 1'b0;
        chk("b2b_rd_count", n_rd, 3);
        chk("b2b_fd_count", n_fd, 3);
        if (n_rd >= 3) begin
            chk("b2b_gap1", r[1] - r[0], 23);
            chk("b2b_gap2", r[2] - r[1], 23);
        end
        step(5);

        // reset during data bit 1 (bit 1 of 3'b101 is 0)
        push(0, 3'b101);
        en[0] = 1'b1;
        wait_rd(0, 10, s);
        en[0] = 1'b0;
        if (s >= 0) begin
            wait_cyc(s + 11);
            chk("mrst_pre_tx", tx_w[0], 0);
            rst = 1'b1;
            step();
            chk("mrst_tx", tx_w[0], 1);
            chk("mrst_busy", bz_w[0], 0);
            chk("mrst_fd", fd_w[0], 0);
            rst = 1'b0;
            n_fd = 0;
            n_low = 0;
            for (int i = 0; i < 30; i++) begin
                step();
                n_fd  += int'(fd_w[0]);
                n_low += int'(!tx_w[0]);
            end
            chk("mrst_no_fd", n_fd, 0);
            chk("mrst_tx_idle", n_low, 0);
        end

        // enable dropped during the start bit, second word left in the FIFO
        push(0, 3'b110);
        push(0, 3'b001);
        en[0] = 1'b1;
        wait_rd(0, 10, s);
        if (s >= 0) begin
            wait_cyc(s + 3);
            chk("endrop_busy", bz_w[0], 1);
            en[0] = 1'b0;
            n_rd = 0;
            n_fd = 0;
            for (int i = 0; i < 60; i++) begin
                step();
                n_rd += int'(rd_w[0]);
                n_fd += int'(fd_w[0]);
            end
            chk("endrop_no_rd", n_rd, 0);
            chk("endrop_fd", n_fd, 1);
        end
        en[0] = 1'b0;

        // random traffic, enable and occasional reset, checked by the reference
        for (int i = 0; i < 1500; i++) begin
            step();
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(7) == 0 && tail[d] - head[d] < 60)
                    push(d, DW'($urandom));
                if ($urandom_range(15) == 0)
                    en[d] = ($urandom_range(3) != 0);
            end
            rst = ($urandom_range(299) == 0);
        end
        rst = 1'b0;
        en[0] = 1'b0;
        en[1] = 1'b0;
        step(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/fifo_serial_tx.md
# fifo_serial_tx

Downstream drain stage for the FIFO block. It pops one word at a time from the FIFO by issuing a single-cycle read strobe on the FIFO's `rclk`. It captures the FIFO's `datout` and shifts it out LSB-first as an asynchronous serial frame (start bit, data, optional even parity, stop bit). It runs on one system clock and paces the FIFO so that a new word is read only when the previous frame has finished.

## Interface
- `DATO_WIDTH`, default 3: data bits per word; matches the FIFO word width.
- `CLKS_PER_BIT`, default 4: `clk` cycles per serial bit. Must be ≥ 2.
- `PARITY`, default 0: 0 = no parity bit; 1 = even parity bit after the data bits.

Ports:
- `clk` in 1: single system clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: permits starting new reads. Does not abort a frame in progress.
- `empy` in 1: FIFO empty flag.
- `datin` in `DATO_WIDTH`: FIFO `datout`.
- `rd` out 1: read strobe to the FIFO `rclk`. Registered; high for exactly one `clk` cycle per word.
- `tx` out 1: serial line. Registered; idles high.
- `busy` out 1: high from READ through STOP inclusive.
- `frame_done` out 1: one-cycle pulse in the cycle after the stop bit completes.

## Operation
- Reset values, effective at the first rising edge with `rst`=1:
  - `tx`=1, `rd`=0, `busy`=0, `frame_done`=0.
  - FSM in IDLE; bit and divider counters 0; shift register 0.
- FSM states: IDLE, READ, WAIT, START, DATA, PAR, STOP.
- IDLE:
  - If `enable`=1 and `empy`=0 at the edge, go to READ.
  - Otherwise stay.
  - `frame_done` deasserts here unless set by the STOP exit.
- READ: `rd`=1 for this one cycle; go to WAIT unconditionally.
- WAIT:
  - `rd`=0; one cycle for the FIFO `datout` to settle.
  - At the exiting edge, load `datin` into the shift register and compute parity = XOR of all data bits.
  - Go to START.
  - `empy` is ignored in READ and WAIT.
- START: `tx`=0 for `CLKS_PER_BIT` cycles.
- DATA:
  - `tx` = shift register bit 0.
  - After each `CLKS_PER_BIT` cycles, shift right and increment the bit counter.
  - After `DATO_WIDTH` bits, go to PAR if `PARITY`=1, else STOP.
- PAR: `tx` = parity bit for `CLKS_PER_BIT` cycles.
- STOP:
  - `tx`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
  - `frame_done`=1 for the single IDLE cycle that follows.
- Counter widths:
  - Divider: clog2(`CLKS_PER_BIT`) bits; counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary.
  - Bit counter: clog2(`DATO_WIDTH`+1) bits.
- `enable` falling mid-frame: the current frame completes normally; no further READ.
- `empy` toggling during a frame has no effect until IDLE.
- Reset mid-frame:
  - At the next edge, all outputs return to reset values and the FSM returns to IDLE.
  - The word already popped is discarded.
  - No partial stop bit is emitted; `tx` simply goes high.
- `rd` is never asserted while IDLE sees `empy`=1. It is never asserted in two consecutive cycles.

## Timing
- Edge E0: IDLE samples `enable`=1, `empy`=0.
- `rd` is high in cycle E0→E1.
- `datin` is captured at edge E2.
- `tx` falls at E2 (start bit begins).
- Frame length on `tx`: (2 + `DATO_WIDTH` + `PARITY`) × `CLKS_PER_BIT` cycles. With defaults, 20 cycles: start E2–E6, data E6–E18, stop E18–E22.
- `frame_done` is high E22–E23.
- Back-to-back words with `empy`=0 continuously: `rd` pulse period = 3 + (2 + `DATO_WIDTH` + `PARITY`) × `CLKS_PER_BIT`. This is 23 cycles with defaults, 27 with `PARITY`=1.
- `busy` is high E1–E22.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles with `empy`=0 and `enable`=1 → `tx`=1, `rd`=0, `busy`=0, `frame_done`=0 throughout; first `rd` occurs the cycle after `rst` falls.
- **Single word, defaults:** `datin`=3'b101; `empy` low for one IDLE sample, then high → one `rd` pulse. `tx` = 0,1,0,1,1, each held 4 cycles, starting 2 edges after `rd` rises. `frame_done` pulses 20 cycles after `tx` falls. No second `rd`.
- **Empty hold:** `empy`=1 and `enable`=1 for 100 cycles → `rd` never asserted; `tx` stays 1.
- **Back-to-back:** FIFO preloaded with 3'b001, 3'b110, 3'b111 → `rd` pulses exactly 23 cycles apart. `tx` data bits are 1,0,0 / 0,1,1 / 1,1,1. Exactly 3 `frame_done` pulses.
- **Parity, `PARITY`=1:** word 3'b110 → `tx` = 0,0,1,1,0,1, each held 4 cycles (parity bit 0). Word 3'b100 → parity bit 1.
- **Mid-frame reset and enable drop:**
  - Assert `rst` for 1 cycle during data bit 1 → `tx`=1 and `busy`=0 at the next edge, with no `frame_done`.
  - Separately, drop `enable` during START → the frame completes and no further `rd` is issued.
